// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache: controller states,
// width helper and word-address field extraction.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    // Index width for n entries; never below 1 so single-entry vectors stay legal.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int off_w);
        return addr & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int off_w,
                                               input int idx_w);
        return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                             input int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

endpackage

// File: rtl/cache_way_store.sv
// One cache way: data words, tag, valid and dirty for every set.
// Reads are combinational; writes land on the rising edge.
module cache_way_store #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int IDX_W  = 8,
    parameter int OFF_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    input  logic              data_we,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              meta_we,
    input  logic [TAG_W-1:0]  meta_tag,
    input  logic              meta_dirty
);
    localparam int SETS  = 1 << IDX_W;
    localparam int WORDS = 1 << OFF_W;

    logic [DATA_W-1:0] data_mem [SETS*WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;

    assign rd_data  = data_mem[{idx, rd_off}];
    assign rd_tag   = tag_mem[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

    always_ff @(posedge clk) begin
        if (data_we) data_mem[{idx, wr_off}] <= wr_data;
        if (meta_we) tag_mem[idx] <= meta_tag;
    end

    // A metadata write always leaves the line valid (refill completion or write hit).
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= meta_dirty;
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with per-set round-robin
// replacement and a word-serial valid/ready memory port.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int WORDS  = 16,
    parameter int SETS   = 256,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        dbg_state
);
    localparam int OFF_W = clog2w(WORDS);
    localparam int IDX_W = clog2w(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = clog2w(WAYS);

    generate
        if (TAG_W < 1 || ADDR_W > 32) begin : g_param_check
            $error("set_assoc_cache: ADDR_W must leave at least one tag bit and fit 32 bits");
        end
    endgenerate

    state_t state_q, state_d;
    logic [OFF_W-1:0]  cnt_q;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [OFF_W-1:0]  off_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WAY_W-1:0]  way_q;
    logic [WAY_W-1:0]  rr_q [SETS];

    logic [DATA_W-1:0] w_data [WAYS];
    logic [TAG_W-1:0]  w_tag  [WAYS];
    logic [WAYS-1:0]   w_valid, w_dirty, w_data_we, w_meta_we;
    logic [OFF_W-1:0]  rd_off, wr_off;
    logic [DATA_W-1:0] wr_data;
    logic              meta_dirty;

    logic              hit, inv_found, victim_dirty, last_word;
    logic [WAY_W-1:0]  hit_way, inv_way, victim_way, sel_way;

    assign dbg_state = state_q;
    assign last_word = (cnt_q == OFF_W'(WORDS - 1));
    // Writeback streams the victim line out; every other state reads the requested word.
    assign rd_off    = (state_q == WRITEBACK) ? cnt_q : off_q;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_store #(
            .DATA_W(DATA_W), .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .idx       (idx_q),
            .rd_off    (rd_off),
            .rd_data   (w_data[w]),
            .rd_tag    (w_tag[w]),
            .rd_valid  (w_valid[w]),
            .rd_dirty  (w_dirty[w]),
            .data_we   (w_data_we[w]),
            .wr_off    (wr_off),
            .wr_data   (wr_data),
            .meta_we   (w_meta_we[w]),
            .meta_tag  (tag_q),
            .meta_dirty(meta_dirty)
        );
    end

    // Descending scan so the lowest-index match and lowest-index invalid way win.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_valid[w] && (w_tag[w] == tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!w_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_way   = inv_found ? inv_way : rr_q[idx_q];
    assign sel_way      = hit ? hit_way : victim_way;
    assign victim_dirty = w_valid[victim_way] & w_dirty[victim_way];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            state_q <= state_d;
            if (mem_valid && mem_ready) cnt_q <= cnt_q + OFF_W'(1);
            if (state_q == REFILL && mem_ready && last_word)
                rr_q[idx_q] <= (rr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_q] + WAY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            tag_q   <= TAG_W'(addr_tag(32'(req_addr), OFF_W, IDX_W));
            idx_q   <= IDX_W'(addr_index(32'(req_addr), OFF_W, IDX_W));
            off_q   <= OFF_W'(addr_offset(32'(req_addr), OFF_W));
            we_q    <= req_we;
            wdata_q <= req_wdata;
        end
        if (state_q == LOOKUP) way_q <= sel_way;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_valid) state_d = LOOKUP;
            LOOKUP:    state_d = hit ? RESPOND : (victim_dirty ? WRITEBACK : REFILL);
            WRITEBACK: if (mem_ready && last_word) state_d = REFILL;
            REFILL:    if (mem_ready && last_word) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Memory handshake: mem_valid/mem_we/mem_addr/mem_wdata depend only on state and
    // burst count, so they hold steady for as long as mem_ready stays low.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        w_data_we  = '0;
        w_meta_we  = '0;
        wr_off     = off_q;
        wr_data    = wdata_q;
        meta_dirty = 1'b1;
        case (state_q)
            IDLE: req_ready = !rst;
            LOOKUP: begin
                if (hit && we_q) begin
                    w_data_we[hit_way] = 1'b1;
                    w_meta_we[hit_way] = 1'b1;
                end
            end
            WRITEBACK: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {w_tag[way_q], idx_q, cnt_q};
                mem_wdata = w_data[way_q];
            end
            REFILL: begin
                mem_valid = 1'b1;
                mem_addr  = {tag_q, idx_q, cnt_q};
                wr_off    = cnt_q;
                wr_data   = (we_q && cnt_q == off_q) ? wdata_q : mem_rdata;
                if (mem_ready) begin
                    w_data_we[way_q] = 1'b1;
                    if (last_word) begin
                        w_meta_we[way_q] = 1'b1;
                        meta_dirty       = we_q;
                    end
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                resp_rdata = w_data[way_q];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: transaction-level cache/memory model,
// per-cycle compare process and hand-computed literal expectations.
module tb_set_assoc_cache;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int WORDS  = 16;
  localparam int SETS   = 256;
  localparam int WAYS   = 2;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_valid;
  logic              mem_ready = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [2:0]        dbg_state;

  set_assoc_cache #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // memory image: words never written read back as their own address
  logic [31:0] mem_img [int];

  function automatic logic [31:0] mem_rd(input int a);
    if (mem_img.exists(a)) return mem_img[a];
    return 32'(a);
  endfunction

  // memory responder with one programmable stall burst
  logic [ADDR_W-1:0] stall_addr = '0;
  int stall_len  = 0;
  int stall_done = 0;

  always @(posedge clk) begin
    #1;
    if (mem_valid && !mem_we && mem_addr == stall_addr && stall_done < stall_len) begin
      mem_ready = 1'b0;
      stall_done++;
    end else begin
      mem_ready = 1'b1;
    end
    mem_rdata = mem_rd(int'(mem_addr));
  end

  // behavioural cache model, updated once per accepted request
  logic [31:0] m_data  [SETS][WAYS][WORDS];
  int          m_tag   [SETS][WAYS];
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int          m_rr    [SETS];

  logic [49:0] exp_mem_q[$];   // {we, addr, data}
  logic [47:0] exp_resp_q[$];  // {latency, rdata}
  int exp_extra = 0;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  task automatic model_access(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    int ai, tag, idx, off, way, lat, la;
    ai  = int'(a);
    tag = ai / (WORDS * SETS);
    idx = (ai / WORDS) % SETS;
    off = ai % WORDS;
    way = -1;
    lat = 2;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
    if (way < 0) begin
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[idx][w]) way = w;
      if (way < 0) way = m_rr[idx];
      if (m_valid[idx][way] && m_dirty[idx][way]) begin
        for (int i = 0; i < WORDS; i++) begin
          la = m_tag[idx][way] * WORDS * SETS + idx * WORDS + i;
          exp_mem_q.push_back({1'b1, 17'(la), m_data[idx][way][i]});
          mem_img[la] = m_data[idx][way][i];
        end
        lat += WORDS;
      end
      for (int i = 0; i < WORDS; i++) begin
        la = tag * WORDS * SETS + idx * WORDS + i;
        m_data[idx][way][i] = mem_rd(la);
        exp_mem_q.push_back({1'b0, 17'(la), m_data[idx][way][i]});
      end
      lat += WORDS;
      m_tag[idx][way]   = tag;
      m_valid[idx][way] = 1'b1;
      m_dirty[idx][way] = 1'b0;
      m_rr[idx]         = (m_rr[idx] + 1) % WAYS;
    end
    if (we) begin
      m_data[idx][way][off] = wd;
      m_dirty[idx][way]     = 1'b1;
    end
    exp_resp_q.push_back({16'(lat + exp_extra), m_data[idx][way][off]});
  endtask

  // compare process: samples mid-cycle, when inputs and outputs are settled
  int cyc = 0;
  int acc_cyc = 0;
  int n_mem = 0;
  int n_resp = 0;
  int last_lat = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] wb13 = '0;
  logic stall_prev = 1'b0;
  logic prev_we = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_wdata = '0;
  logic [49:0] em;
  logic [47:0] er;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      model_reset();
      exp_mem_q.delete();
      exp_resp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", mem_valid, 1'b1);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_we", mem_we, prev_we);
        check("hold_wdata", mem_wdata, prev_wdata);
      end
      stall_prev = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
      if (req_valid && req_ready) begin
        model_access(req_we, req_addr, req_wdata);
        acc_cyc = cyc;
        n_mem = 0;
      end
      if (mem_valid && mem_ready) begin
        n_mem++;
        if (mem_we && mem_addr == 17'h00013) wb13 = mem_wdata;
        if (exp_mem_q.size() == 0) begin
          fail_now("mem_unexpected", $sformatf("transfer we=%0d addr=0x%0h, none expected", mem_we, mem_addr));
        end else begin
          em = exp_mem_q.pop_front();
          check("mem_we", mem_we, em[49]);
          check("mem_addr", mem_addr, em[48:32]);
          if (em[49]) check("mem_wdata", mem_wdata, em[31:0]);
        end
      end
      if (resp_valid) begin
        n_resp++;
        last_rdata = resp_rdata;
        last_lat   = cyc - acc_cyc;
        if (exp_resp_q.size() == 0) begin
          fail_now("resp_unexpected", $sformatf("resp_rdata=0x%0h, none expected", resp_rdata));
        end else begin
          er = exp_resp_q.pop_front();
          check("resp_rdata", resp_rdata, er[31:0]);
          check("resp_latency", cyc - acc_cyc, er[47:32]);
        end
      end
    end
  end

  // driver tasks
  task automatic send_req(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                          input int extra);
    bit ok;
    exp_extra = extra;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) fail_now("accept_timeout", "req_ready never seen within 100 cycles");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    bit got;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) got = 1;
    end
    if (!got) fail_now("resp_timeout", "resp_valid never seen within 200 cycles");
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input int extra);
    send_req(we, a, wd, extra);
    wait_resp();
  endtask

  initial begin
    bit found;
    int r0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 17'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_state_idle", dbg_state, 3'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);

    // cold read miss, then hit in the same line
    do_req(1'b0, 17'h00013, 32'h0, 0);
    check("cold_rdata", last_rdata, 32'h00013);
    check("cold_latency", last_lat, 18);
    check("cold_mem_count", n_mem, 16);
    do_req(1'b0, 17'h00015, 32'h0, 0);
    check("hit_rdata", last_rdata, 32'h00015);
    check("hit_latency", last_lat, 2);
    check("hit_mem_count", n_mem, 0);
    check("hit_ready_again", req_ready, 1'b1);

    // write hit, then read it back
    do_req(1'b1, 17'h00013, 32'hDEADBEEF, 0);
    check("wr_hit_rdata", last_rdata, 32'hDEADBEEF);
    check("wr_hit_mem_count", n_mem, 0);
    do_req(1'b0, 17'h00013, 32'h0, 0);
    check("rd_after_wr", last_rdata, 32'hDEADBEEF);

    // fill the second way, then evict the dirty first way
    do_req(1'b0, 17'h01013, 32'h0, 0);
    check("way1_rdata", last_rdata, 32'h01013);
    check("way1_latency", last_lat, 18);
    do_req(1'b0, 17'h02013, 32'h0, 0);
    check("evict_rdata", last_rdata, 32'h02013);
    check("evict_latency", last_lat, 34);
    check("evict_mem_count", n_mem, 32);
    check("evict_wb_word13", wb13, 32'hDEADBEEF);

    // refill stalled for 5 cycles at word 7
    stall_addr = 17'h00017;
    stall_len  = 5;
    do_req(1'b0, 17'h00017, 32'h0, 5);
    check("stall_rdata", last_rdata, 32'h00017);
    check("stall_latency", last_lat, 23);
    do_req(1'b0, 17'h00013, 32'h0, 0);
    check("refetched_dirty_word", last_rdata, 32'hDEADBEEF);
    check("refetched_latency", last_lat, 2);

    // reset in the middle of a refill
    send_req(1'b0, 17'h03040, 32'h0, 0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_valid && mem_addr == 17'h03044) found = 1;
    end
    if (!found) fail_now("refill_word4_timeout", "refill word 4 never presented");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_mem_valid", mem_valid, 1'b0);
    check("midrst_state_idle", dbg_state, 3'd0);
    @(negedge clk);
    check("midrst_req_ready", req_ready, 1'b1);
    do_req(1'b0, 17'h03040, 32'h0, 0);
    check("reread_rdata", last_rdata, 32'h03040);
    check("reread_latency", last_lat, 18);
    check("reread_mem_count", n_mem, 16);

    // requests offered while busy are ignored
    r0 = n_resp;
    send_req(1'b0, 17'h04020, 32'h0, 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      req_valid = i[0];
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 17'($urandom_range(0, 17'h1FFFF));
      req_wdata = $urandom;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp();
    repeat (25) @(posedge clk);
    #1;
    check("busy_rdata", last_rdata, 32'h04020);
    check("busy_latency", last_lat, 18);
    check("busy_resp_count", n_resp - r0, 1);

    check("exp_mem_left", exp_mem_q.size(), 0);
    check("exp_resp_left", exp_resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative write-back, write-allocate cache with per-set round-robin replacement. It sits between a single-issue core request port and a word-serial main-memory port. It replaces the fixed direct-mapped cache, whose 3-bit tag and single way were hard-wired. Memory traffic uses an explicit valid/ready handshake, so it can stall on slow memory instead of completing a whole block transfer in one clock.

## Interface
- ADDR_W, 17: word address width (core and memory side).
- DATA_W, 32: word width.
- WORDS, 16: words per line; power of 2, ≥2.
- SETS, 256: number of sets; power of 2, ≥2.
- WAYS, 2: associativity; power of 2, 1..8.
- Derived: OFF_W=log2(WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, which must be ≥1 (checked at elaboration).
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  cache can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address {tag, index, offset}.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  DATA_W  read data; for writes, the written word.
- mem_valid  out  1  memory word transfer requested.
- mem_ready  in  1  memory accepts the transfer (read data valid this cycle).
- mem_we  out  1  1 = writeback word, 0 = refill word.
- mem_addr  out  ADDR_W  word address of the transfer.
- mem_wdata  out  DATA_W  writeback data.
- mem_rdata  in  DATA_W  refill data, sampled when mem_valid & mem_ready & !mem_we.

## Operation
- FSM states:
  - IDLE → LOOKUP on req_valid & req_ready.
  - LOOKUP → RESPOND on hit.
  - LOOKUP → WRITEBACK on miss with a dirty victim.
  - LOOKUP → REFILL on miss with a clean victim.
  - WRITEBACK → REFILL after the last word.
  - REFILL → RESPOND after the last word.
  - RESPOND → IDLE.
- req_ready = 1 only in IDLE and not in reset. The request is latched at acceptance; req_* are ignored in all other states.
- Hit: tag match in any way with valid=1. A read returns the word. A write updates the word and sets dirty.
- Victim selection: lowest-index invalid way; if all ways are valid, the way at the set's rr pointer. The pointer advances (mod WAYS) on every refill into that set.
- WRITEBACK: WORDS transfers, mem_we=1, mem_addr={victim tag, index, offset 0..WORDS-1} ascending.
- REFILL: WORDS transfers, mem_we=0, requested tag, ascending offsets. At completion: tag written, valid=1, dirty=0. A write request then merges its word and sets dirty=1.
- Each transfer completes on mem_valid & mem_ready. mem_valid, mem_we, mem_addr and mem_wdata hold stable while mem_ready=0.
- Arithmetic: burst offset counter is OFF_W bits and wraps; the last word is detected at count WORDS-1. Tags compare at full TAG_W.

## Timing
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All valid, dirty and rr pointers cleared; data and tag storage not reset.
  - First cycle after rst falls: IDLE, req_ready=1.
- Hit latency: request accepted at edge k; LOOKUP during cycle k+1; resp_valid high during cycle k+2 only; req_ready high again at cycle k+3.
- Miss latency with zero memory stalls: 2 + WORDS·(1 + dirty) cycles from acceptance to resp_valid.
- mem_valid rises the cycle after LOOKUP. It stays high continuously across back-to-back words and across the WRITEBACK→REFILL boundary.
- Reset mid-burst: next cycle mem_valid=0 and the FSM is in IDLE. Partially transferred dirty data is lost and the line is left invalid.
- req_valid during a busy state: no effect, no loss of the latched request.

## Structure
- Package cache_pkg holds:
  - the state enum (IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND);
  - a clog2-based width helper;
  - the tag/index/offset field-extraction functions.
- Sub-module cache_way_store: one per way via generate, holding data, tag, valid and dirty for all sets. Read is combinational, write is synchronous. The top module keeps the FSM, burst counter and rr pointers.

## Test plan
Defaults are ADDR_W=17, WORDS=16, SETS=256, WAYS=2; the memory model returns data = address.
- Cold read 0x00013 → 16 reads at 0x00010..0x0001F, resp_rdata=0x00013 at acceptance+18. Then read 0x00015 → resp_rdata=0x00015 at acceptance+2, mem_valid stays 0.
- Write 0x00013 data 0xDEADBEEF (hit) → no memory traffic. Read 0x00013 → 0xDEADBEEF.
- Read 0x01013, then read 0x02013 (same index, third tag) → way 0 evicted: 16 writes at 0x00010..0x0001F, with the word at 0x00013=0xDEADBEEF, then 16 reads from 0x02010. resp_rdata=0x02013.
- Hold mem_ready=0 for 5 cycles at refill word 7 → mem_addr stays 0x00017 and mem_valid stays 1. Completion is delayed by exactly 5 cycles.
- Assert rst for 1 cycle during refill word 4 → mem_valid=0 next cycle, req_ready=1 the cycle after. A re-read of the same address misses again.
- Toggle req_valid with different addresses during a miss → only the latched request completes, with one resp_valid pulse.
